seq_priority_encoder: RTL and testbench
=======================================

SEQ_PRIORITY_ENCODER -- requirements
Module: seq_priority_encoder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the request vector width; legal range 2..64.
REQ-002 Parameter IDX_W, default $clog2(WIDTH), SHALL set the encoded index width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_in  input  WIDTH  one-hot or multi-hot request vector.
REQ-007 req_valid  input  1  req_in is valid.
REQ-008 req_ready  output  1  block can capture a vector.
REQ-009 enc_out  output  IDX_W  index of the set bit being emitted.
REQ-010 enc_valid  output  1  enc_out, enc_none and enc_last are valid.
REQ-011 enc_ready  input  1  consumer accepts the current beat.
REQ-012 enc_last  output  1  current beat is the final beat for the captured vector.
REQ-013 enc_none  output  1  captured vector was all-zero.

Function
REQ-014 FSM states SHALL be IDLE and EMIT.
REQ-015 req_ready SHALL equal (state == IDLE), with no dependency on enc_ready.
REQ-016 In IDLE, req_valid && req_ready SHALL capture req_in into a pending mask and enter EMIT on the next edge.
REQ-017 First enc_valid SHALL assert the cycle after capture; capture-to-output latency is 1 cycle.
REQ-018 In EMIT, enc_out SHALL be the index of the lowest set bit of the pending mask.
REQ-019 An enc_valid && enc_ready handshake SHALL clear the emitted bit, giving one beat per cycle under continuous enc_ready.
REQ-020 enc_last SHALL be 1 exactly when the pending mask has one bit set, or when enc_none=1.
REQ-021 A handshake on a beat with enc_last=1 SHALL return the FSM to IDLE; enc_valid=0 and req_ready=1 on the next cycle.
REQ-022 An all-zero capture SHALL emit one beat: enc_none=1, enc_out=0, enc_last=1.
REQ-023 While enc_valid=1 and enc_ready=0, enc_out, enc_last and enc_none SHALL hold stable.
REQ-024 req_valid asserted during EMIT SHALL be ignored, with no capture and no side effects.
REQ-025 enc_valid SHALL never assert in IDLE.
REQ-026 All outputs except req_ready SHALL be driven from registers.

Reset
REQ-027 rst_n low SHALL force state=IDLE, pending mask=0, and enc_out, enc_valid, enc_last and enc_none to 0, immediately and asynchronously.
REQ-028 Assertion of rst_n mid-EMIT SHALL discard all pending bits; no beat is emitted after deassertion until a new capture.
REQ-029 req_ready SHALL read 1 during and after reset.

Configuration
REQ-030 With macro SEQ_PRIORITY_ENCODER_MSB_FIRST_EN defined, emission order SHALL be highest set bit first, and all other rules are unchanged.
REQ-031 Without SEQ_PRIORITY_ENCODER_MSB_FIRST_EN, emission order SHALL be lowest set bit first.

Structure
REQ-032 Package seq_priority_encoder_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-033 Sub-module first_set_finder (combinational, parameterised WIDTH and direction) SHALL return the selected index and a one-bit "more than one set" flag.

Verification (WIDTH=8 unless stated)
REQ-034 Capture 8'b00010110 with enc_ready=1 -> enc_out 1, 2, 4 on three consecutive cycles, enc_last only on 4, then req_ready=1.
REQ-035 Capture 8'h00 -> a single beat with enc_none=1, enc_out=0, enc_last=1.
REQ-036 Capture 8'b10000001 with enc_ready=0 for 3 cycles -> enc_out=0 held for 3 cycles; then 0 and 7 are emitted; req_valid pulsed with 8'hFF during EMIT is not captured.
REQ-037 Capture 8'hFF, then drop rst_n after 2 beats -> all outputs are 0 at once, and no further beats occur until a new capture.
REQ-038 With SEQ_PRIORITY_ENCODER_MSB_FIRST_EN defined and WIDTH=4, capture 4'b1011 -> enc_out 3, 1, 0; a capture of 4'b1000 alone -> one beat with enc_out=3 and enc_last=1.

Source files
------------

// File: rtl/seq_priority_encoder_pkg.sv
// Shared types for seq_priority_encoder: FSM state encoding and default request width.
package seq_priority_encoder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  localparam logic [0:0] IDLE = S_IDLE;
  localparam logic [0:0] EMIT = S_EMIT;

endpackage

// File: rtl/first_set_finder.sv
// Combinational bit picker: lowest (or highest when MSB_FIRST) set index plus a multi-hot flag.
// Zero latency; no flow control.
module first_set_finder #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             multi
);

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi = |(vec & (vec - WIDTH'(1)));

  // Later loop iterations win, so the scan direction picks the priority end.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/seq_priority_encoder.sv
// Captures a request vector and emits one set-bit index per accepted beat; first beat 1 cycle after capture.
// Holds the beat while enc_ready is low; req_ready only in IDLE. Define SEQ_PRIORITY_ENCODER_MSB_FIRST_EN for highest-bit-first order.
module seq_priority_encoder
  import seq_priority_encoder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_in,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [IDX_W-1:0] enc_out,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic             enc_last,
  output logic             enc_none
);

`ifdef SEQ_PRIORITY_ENCODER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic [0:0]       state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] find_vec;
  logic [IDX_W-1:0] find_idx;
  logic             find_multi;
  logic             fire;

  assign req_ready = (state == IDLE);
  assign fire      = enc_valid && enc_ready;

  // One finder serves both the fresh capture and the mask left after the current beat.
  assign find_vec = (state == IDLE) ? req_in : (pending & ~(WIDTH'(1) << enc_out));

  first_set_finder #(
    .WIDTH    (WIDTH),
    .IDX_W    (IDX_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_finder (
    .vec  (find_vec),
    .idx  (find_idx),
    .multi(find_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      enc_out   <= '0;
      enc_valid <= 1'b0;
      enc_last  <= 1'b0;
      enc_none  <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        state     <= EMIT;
        pending   <= req_in;
        enc_valid <= 1'b1;
        enc_out   <= find_idx;
        enc_last  <= !find_multi;
        enc_none  <= ~|req_in;
      end
    end else if (fire) begin
      if (enc_last) begin
        state     <= IDLE;
        pending   <= '0;
        enc_out   <= '0;
        enc_valid <= 1'b0;
        enc_last  <= 1'b0;
        enc_none  <= 1'b0;
      end else begin
        pending  <= find_vec;
        enc_out  <= find_idx;
        enc_last <= !find_multi;
      end
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder (WIDTH=8): vector table plus stall, ignored-request and mid-emit reset sequences.
module tb_seq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_in = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] enc_out;
  logic       enc_valid;
  logic       enc_ready = 1'b0;
  logic       enc_last;
  logic       enc_none;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_priority_encoder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .enc_out  (enc_out),
    .enc_valid(enc_valid),
    .enc_ready(enc_ready),
    .enc_last (enc_last),
    .enc_none (enc_none)
  );

  // seq lists beat indices one per nibble, first beat in the top nibble.
  typedef struct packed {
    logic [7:0]  vec;
    logic [3:0]  n;
    logic        none;
    logic [31:0] seq;
  } vec_t;

  vec_t tbl [7];

`ifdef SEQ_PRIORITY_ENCODER_MSB_FIRST_EN
  localparam logic [2:0] STALL_FIRST  = 3'd7;
  localparam logic [2:0] STALL_SECOND = 3'd0;
`else
  localparam logic [2:0] STALL_FIRST  = 3'd0;
  localparam logic [2:0] STALL_SECOND = 3'd7;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (req_ready !== 1'b1 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_wait", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
`ifdef SEQ_PRIORITY_ENCODER_MSB_FIRST_EN
    tbl[0] = '{8'b00010110, 4'd3, 1'b0, 32'h4210_0000};
    tbl[1] = '{8'b00000001, 4'd1, 1'b0, 32'h0000_0000};
    tbl[2] = '{8'b10000000, 4'd1, 1'b0, 32'h7000_0000};
    tbl[3] = '{8'b11111111, 4'd8, 1'b0, 32'h7654_3210};
    tbl[4] = '{8'b00000000, 4'd1, 1'b1, 32'h0000_0000};
    tbl[5] = '{8'b00001011, 4'd3, 1'b0, 32'h3100_0000};
    tbl[6] = '{8'b00001000, 4'd1, 1'b0, 32'h3000_0000};
`else
    tbl[0] = '{8'b00010110, 4'd3, 1'b0, 32'h1240_0000};
    tbl[1] = '{8'b00000001, 4'd1, 1'b0, 32'h0000_0000};
    tbl[2] = '{8'b10000000, 4'd1, 1'b0, 32'h7000_0000};
    tbl[3] = '{8'b11111111, 4'd8, 1'b0, 32'h0123_4567};
    tbl[4] = '{8'b00000000, 4'd1, 1'b1, 32'h0000_0000};
    tbl[5] = '{8'b00001011, 4'd3, 1'b0, 32'h0130_0000};
    tbl[6] = '{8'b00001000, 4'd1, 1'b0, 32'h3000_0000};
`endif

    // Reset state
    #2;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_enc_valid", {63'd0, enc_valid}, 64'd0);
    chk("rst_enc_out",   {61'd0, enc_out},   64'd0);
    chk("rst_enc_last",  {63'd0, enc_last},  64'd0);
    chk("rst_enc_none",  {63'd0, enc_none},  64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table: capture each vector with enc_ready held high
    for (int e = 0; e < 7; e++) begin
      wait_idle();
      @(negedge clk);
      req_valid = 1'b1;
      req_in    = tbl[e].vec;
      enc_ready = 1'b1;
      for (int k = 0; k < int'(tbl[e].n); k++) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk($sformatf("tbl%0d_b%0d_valid", e, k), {63'd0, enc_valid}, 64'd1);
        chk($sformatf("tbl%0d_b%0d_out", e, k), {61'd0, enc_out}, {60'd0, tbl[e].seq[31-4*k -: 4]});
        chk($sformatf("tbl%0d_b%0d_last", e, k), {63'd0, enc_last}, {63'd0, k == int'(tbl[e].n) - 1});
        chk($sformatf("tbl%0d_b%0d_none", e, k), {63'd0, enc_none}, {63'd0, tbl[e].none});
        chk($sformatf("tbl%0d_b%0d_rdy", e, k), {63'd0, req_ready}, 64'd0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_end_valid", e), {63'd0, enc_valid}, 64'd0);
      chk($sformatf("tbl%0d_end_rdy", e), {63'd0, req_ready}, 64'd1);
    end

    // Stall for 3 cycles with a request pulse during EMIT
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1;
    req_in    = 8'b10000001;
    enc_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_valid", c), {63'd0, enc_valid}, 64'd1);
      chk($sformatf("stall%0d_out", c), {61'd0, enc_out}, {61'd0, STALL_FIRST});
      chk($sformatf("stall%0d_last", c), {63'd0, enc_last}, 64'd0);
      chk($sformatf("stall%0d_none", c), {63'd0, enc_none}, 64'd0);
      @(negedge clk);
      req_valid = (c == 0);
      req_in    = (c == 0) ? 8'hFF : 8'h00;
    end
    enc_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_b1_out",  {61'd0, enc_out},  {61'd0, STALL_SECOND});
    chk("stall_b1_last", {63'd0, enc_last}, 64'd1);
    @(posedge clk);
    #1;
    chk("stall_end_rdy", {63'd0, req_ready}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_post%0d_valid", c), {63'd0, enc_valid}, 64'd0);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of emitting 8'hFF
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1;
    req_in    = 8'hFF;
    enc_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_valid", {63'd0, enc_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, enc_valid}, 64'd0);
    chk("mid_rst_out",   {61'd0, enc_out},   64'd0);
    chk("mid_rst_last",  {63'd0, enc_last},  64'd0);
    chk("mid_rst_none",  {63'd0, enc_none},  64'd0);
    chk("mid_rst_rdy",   {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_valid", c), {63'd0, enc_valid}, 64'd0);
      chk($sformatf("post_rst%0d_rdy", c), {63'd0, req_ready}, 64'd1);
    end

    // New capture works after the reset
    @(negedge clk);
    req_valid = 1'b1;
    req_in    = 8'b00000100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("recap_valid", {63'd0, enc_valid}, 64'd1);
    chk("recap_out",   {61'd0, enc_out},   64'd2);
    chk("recap_last",  {63'd0, enc_last},  64'd1);
    @(posedge clk);
    #1;
    chk("recap_end_valid", {63'd0, enc_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
